// File: rtl/servo_motion_scheduler_if.sv
// Target-angle command port between a requester (master) and servo_motion_scheduler (slave).
interface servo_motion_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_chan;
    logic [7:0] cmd_angle;

    modport master (output cmd_valid, output cmd_chan, output cmd_angle, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_chan, input cmd_angle, output cmd_ready);
endinterface

// File: rtl/servo_motion_scheduler.sv
// Frame-paced angle sequencer for a 4-channel servo PWM generator.
// Optional macro SERVO_SLEW_EN limits each channel to STEP degrees per frame; without it targets land in one frame.
module servo_motion_scheduler #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int STEP         = 2,
    parameter int MAX_ANGLE    = 180,
    parameter int HOME_ANGLE   = 90
) (
    input  logic                     clk,
    input  logic                     rst,
    servo_motion_scheduler_if.slave  cmd,
    output logic                     nextangle,
    output logic [7:0]               angle1,
    output logic [7:0]               angle2,
    output logic [7:0]               angle3,
    output logic [7:0]               angle4,
    output logic                     busy,
    output logic                     frame_tick
);

`ifdef SERVO_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif

    // With slewing off the limit spans the whole 8-bit range, so every step lands on the target.
    localparam logic [8:0]  STEP_LIMIT = SLEW_EN ? 9'(STEP) : 9'd255;
    localparam logic [23:0] CNT_LAST   = 24'(FRAME_CYCLES - 1);
    localparam logic [23:0] CNT_PRE    = 24'(FRAME_CYCLES - 2);
    localparam logic [7:0]  MAX_A      = 8'(MAX_ANGLE);
    localparam logic [7:0]  HOME_A     = 8'(HOME_ANGLE);

    localparam logic [2:0] ST_WAIT  = 3'd0;
    localparam logic [2:0] ST_STEP0 = 3'd1;
    localparam logic [2:0] ST_STEP1 = 3'd2;
    localparam logic [2:0] ST_STEP2 = 3'd3;
    localparam logic [2:0] ST_STEP3 = 3'd4;
    localparam logic [2:0] ST_LOAD  = 3'd5;

    logic [23:0] cnt_r;
    logic        frame_tick_r;
    logic [2:0]  state_r;
    logic [2:0]  state_nx_s;
    logic        nextangle_r;
    logic        busy_r;
    logic [7:0]  tgt_r [4];
    logic [7:0]  cur_r [4];
    logic        cmd_ready_s;
    logic        accept_s;
    logic [7:0]  tgt_in_s;
    logic        diff_s;

    function automatic logic [7:0] slew_next(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] cur9;
        logic [8:0] tgt9;
        logic [8:0] dist9;
        cur9  = {1'b0, cur};
        tgt9  = {1'b0, tgt};
        dist9 = 9'd0;
        if (cur9 < tgt9) begin
            dist9 = tgt9 - cur9;
            if (dist9 > STEP_LIMIT) begin
                dist9 = STEP_LIMIT;
            end else begin
                dist9 = dist9;
            end
            slew_next = 8'(cur9 + dist9);
        end else if (cur9 > tgt9) begin
            dist9 = cur9 - tgt9;
            if (dist9 > STEP_LIMIT) begin
                dist9 = STEP_LIMIT;
            end else begin
                dist9 = dist9;
            end
            slew_next = 8'(cur9 - dist9);
        end else begin
            slew_next = cur;
        end
    endfunction

    assign cmd_ready_s   = (state_r == ST_WAIT) && !rst;
    assign cmd.cmd_ready = cmd_ready_s;
    assign accept_s      = cmd.cmd_valid && cmd_ready_s;
    assign tgt_in_s      = (cmd.cmd_angle > MAX_A) ? MAX_A : cmd.cmd_angle;

    // Free-running frame counter; the tick flop is primed one count early so it is high at the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= 24'd0;
            frame_tick_r <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= 24'd0;
            end else begin
                cnt_r <= cnt_r + 24'd1;
            end
            frame_tick_r <= (cnt_r == CNT_PRE);
        end
    end

    // Sequence: wait for the frame tick, visit each channel once, then strobe the load.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (frame_tick_r) begin
                    state_nx_s = ST_STEP0;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_STEP0: state_nx_s = ST_STEP1;
            ST_STEP1: state_nx_s = ST_STEP2;
            ST_STEP2: state_nx_s = ST_STEP3;
            ST_STEP3: state_nx_s = ST_LOAD;
            ST_LOAD:  state_nx_s = ST_WAIT;
            default:  state_nx_s = ST_WAIT;
        endcase
    end

    // State register and load strobe, which is high exactly while the sequencer sits in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_WAIT;
            nextangle_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            nextangle_r <= (state_r == ST_STEP3);
        end
    end

    // Any channel still away from its target.
    always_comb begin
        diff_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            diff_s = diff_s | (cur_r[i] != tgt_r[i]);
        end
    end

    // Target capture from the command port, per-channel slew, and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tgt_r[i] <= HOME_A;
                cur_r[i] <= HOME_A;
            end
            busy_r <= 1'b0;
        end else begin
            if (accept_s) begin
                tgt_r[cmd.cmd_chan] <= tgt_in_s;
            end
            case (state_r)
                ST_STEP0: cur_r[0] <= slew_next(cur_r[0], tgt_r[0]);
                ST_STEP1: cur_r[1] <= slew_next(cur_r[1], tgt_r[1]);
                ST_STEP2: cur_r[2] <= slew_next(cur_r[2], tgt_r[2]);
                ST_STEP3: cur_r[3] <= slew_next(cur_r[3], tgt_r[3]);
                default: begin
                end
            endcase
            busy_r <= diff_s;
        end
    end

    assign nextangle  = nextangle_r;
    assign frame_tick = frame_tick_r;
    assign busy       = busy_r;
    assign angle1     = cur_r[0];
    assign angle2     = cur_r[1];
    assign angle3     = cur_r[2];
    assign angle4     = cur_r[3];

endmodule

// File: tb/tb_servo_motion_scheduler.sv
// Randomized and directed bench for servo_motion_scheduler against a cycle-count based reference model.
`timescale 1ns/1ps
module tb_servo_motion_scheduler;
    localparam int F    = 16;
    localparam int STEP = 2;
    localparam int MAXA = 180;
    localparam int HOME = 90;
`ifdef SERVO_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       nextangle;
    logic       busy;
    logic       frame_tick;
    logic [7:0] angle1, angle2, angle3, angle4;

    servo_motion_scheduler_if bus ();

    servo_motion_scheduler #(
        .FRAME_CYCLES(F), .STEP(STEP), .MAX_ANGLE(MAXA), .HOME_ANGLE(HOME)
    ) dut (
        .clk(clk), .rst(rst), .cmd(bus), .nextangle(nextangle),
        .angle1(angle1), .angle2(angle2), .angle3(angle3), .angle4(angle4),
        .busy(busy), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: t counts cycles since the last reset edge; frame passes fall at t >= F, t % F in 0..4.
    int t = 0;
    int tgt_m [4];
    int cur_m [4];
    bit busy_m = 1'b0;
    bit chk_en = 1'b0;
    bit hs = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        nchk++;
        nerr++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    function automatic bit in_pass(input int tc);
        return (tc >= F) && ((tc % F) <= 4);
    endfunction

    function automatic int slew(input int c, input int g);
        int d;
        d = g - c;
        if (SLEW) begin
            if (d > STEP) d = STEP;
            else if (d < -STEP) d = -STEP;
        end
        return c + d;
    endfunction

    task automatic model_step();
        int p;
        if (rst === 1'b1) begin
            t = 0;
            for (int i = 0; i < 4; i++) begin
                tgt_m[i] = HOME;
                cur_m[i] = HOME;
            end
            busy_m = 1'b0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            busy_m = 1'b0;
            for (int i = 0; i < 4; i++) if (cur_m[i] != tgt_m[i]) busy_m = 1'b1;
            p = t % F;
            if (in_pass(t) && p < 4) cur_m[p] = slew(cur_m[p], tgt_m[p]);
            if (bus.cmd_valid === 1'b1 && !in_pass(t))
                tgt_m[bus.cmd_chan] = (int'(bus.cmd_angle) > MAXA) ? MAXA : int'(bus.cmd_angle);
            t++;
        end
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("frame_tick", frame_tick, (t % F) == F - 1);
            check("nextangle", nextangle, (t >= F) && ((t % F) == 4));
            check("cmd_ready", bus.cmd_ready, !in_pass(t) && (rst !== 1'b1));
            check("busy", busy, busy_m);
            check("angle1", angle1, cur_m[0]);
            check("angle2", angle2, cur_m[1]);
            check("angle3", angle3, cur_m[2]);
            check("angle4", angle4, cur_m[3]);
        end
    end

    task automatic cyc();
        #2;
        hs = (bus.cmd_valid === 1'b1) && (bus.cmd_ready === 1'b1);
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * F && !ok; i++) begin
            cyc();
            if (frame_tick === 1'b1) ok = 1'b1;
        end
        if (!ok) timeout("wait_tick");
    endtask

    task automatic wait_next(output int n);
        bit ok;
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * F && !ok; i++) begin
            cyc();
            n++;
            if (nextangle === 1'b1) ok = 1'b1;
        end
        if (!ok) timeout("wait_next");
    endtask

    task automatic send(input int ch, input int ang);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_chan  = 2'(ch);
        bus.cmd_angle = 8'(ang);
        for (int i = 0; i < 4 * F && !done; i++) begin
            cyc();
            if (hs) done = 1'b1;
        end
        bus.cmd_valid = 1'b0;
        if (!done) timeout("send");
    endtask

    task automatic measure_after_reset(input string tag);
        int first_tick;
        int first_next;
        first_tick = -1;
        first_next = -1;
        for (int n = 0; n < 24; n++) begin
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = n;
            if (nextangle === 1'b1 && first_next < 0) first_next = n;
            cyc();
        end
        check({tag, "_first_tick"}, first_tick, 15);
        check({tag, "_first_next"}, first_next, 20);
    endtask

    initial begin
        int n;
        int mx;
        int stall;
        bit done;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_chan  = 2'd0;
        bus.cmd_angle = 8'd0;
        repeat (3) cyc();
        rst = 1'b0;
        check("rst_angle1", angle1, 32'd90);
        check("rst_angle4", angle4, 32'd90);
        check("rst_busy", busy, 32'd0);
        check("rst_nextangle", nextangle, 32'd0);
        measure_after_reset("reset");

        // Slew up channel 0 to 100.
        send(0, 100);
        cyc();
        check("busy_after_cmd", busy, 32'd1);
        for (int i = 0; i < 5; i++) begin
            wait_next(n);
            check("slew_up_angle1", angle1, SLEW ? 92 + 2 * i : 100);
            check("slew_up_angle2", angle2, 32'd90);
        end
        check("slew_up_busy_done", busy, 32'd0);

        // Down slew with a non-multiple distance.
        send(2, 85);
        for (int i = 0; i < 3; i++) begin
            wait_next(n);
            check("slew_down_angle3", angle3, SLEW ? ((i == 0) ? 88 : (i == 1) ? 86 : 85) : 85);
        end

        // Out-of-range target is clamped.
        send(3, 250);
        mx = 0;
        for (int i = 0; i < 47; i++) begin
            wait_next(n);
            if (int'(angle4) > mx) mx = int'(angle4);
        end
        check("clamp_settle", angle4, 32'd180);
        check("clamp_max", mx, 32'd180);

        // Command held across a frame pass is stalled for exactly five cycles.
        wait_tick();
        cyc();
        bus.cmd_valid = 1'b1;
        bus.cmd_chan  = 2'd1;
        bus.cmd_angle = 8'd10;
        stall = 0;
        done = 1'b0;
        for (int i = 0; i < 4 * F && !done; i++) begin
            cyc();
            if (hs) done = 1'b1;
            else stall++;
        end
        bus.cmd_valid = 1'b0;
        check("stall_cycles", stall, 32'd5);

        // Command on the frame-tick cycle reaches the same frame's load.
        wait_tick();
        bus.cmd_valid = 1'b1;
        bus.cmd_chan  = 2'd0;
        bus.cmd_angle = 8'd0;
        cyc();
        check("tick_accept", hs, 32'd1);
        bus.cmd_valid = 1'b0;
        wait_next(n);
        check("tick_to_next", n, 32'd4);
        check("tick_cmd_angle1", angle1, SLEW ? 98 : 0);

        // Reset while in STEP2 aborts the pass.
        wait_tick();
        cyc();
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_angle1", angle1, 32'd90);
        check("midrst_angle2", angle2, 32'd90);
        check("midrst_nextangle", nextangle, 32'd0);
        measure_after_reset("midrst");
        send(0, 0);
        wait_next(n);
        check("home_to_zero_angle1", angle1, SLEW ? 88 : 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if (bus.cmd_valid !== 1'b1 && $urandom_range(3) == 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_chan  = 2'($urandom_range(3));
                if ($urandom_range(3) == 0) bus.cmd_angle = 8'($urandom_range(255));
                else bus.cmd_angle = 8'($urandom_range(110, 70));
            end
            rst = ($urandom_range(999) == 0);
            cyc();
            if (hs || rst === 1'b1) bus.cmd_valid = 1'b0;
        end
        rst = 1'b0;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/servo_motion_scheduler.md
Name: servo_motion_scheduler

Overview:
- Sequences angle updates for the 4-channel servo PWM generator.
- Accepts per-channel target angles over a valid/ready command port.
- Slews each channel's commanded angle toward its target by at most STEP degrees per servo frame.
- Presents angle1..angle4 with a one-cycle nextangle load pulse once per frame, so the PWM generator only reloads at frame boundaries.

Parameters:
- FRAME_CYCLES, 1000000: clk cycles per servo frame (20 ms at 50 MHz). Legal range is 8..2^24-1.
- STEP, 2: maximum angle change in degrees per channel per frame. Legal range is 1..255.
- MAX_ANGLE, 180: upper clamp for targets, in degrees.
- HOME_ANGLE, 90: reset value of every target and current angle. Must be <= MAX_ANGLE.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  scheduler can accept a command this cycle
- cmd_chan  in  2  target channel, 0..3
- cmd_angle  in  8  target angle in degrees
- nextangle  out  1  one-cycle load strobe to the PWM generator
- angle1  out  8  current angle, channel 0
- angle2  out  8  current angle, channel 1
- angle3  out  8  current angle, channel 2
- angle4  out  8  current angle, channel 3
- busy  out  1  high while any current angle differs from its target
- frame_tick  out  1  one-cycle pulse at frame terminal count

Behaviour:
- Reset (rst=1 at posedge clk):
  - frame counter = 0; FSM = WAIT.
  - tgt[0..3] = HOME_ANGLE; cur[0..3] = HOME_ANGLE.
  - nextangle = 0, frame_tick = 0, busy = 0, cmd_ready = 0 during reset.
  - Reset mid-frame or mid-step aborts the sequence; no nextangle is issued.
- Frame counter:
  - Free-running 0..FRAME_CYCLES-1, then wraps to 0.
  - It is never stalled by the FSM, so the frame period is exactly FRAME_CYCLES.
  - frame_tick = 1 on the cycle the counter equals FRAME_CYCLES-1.
- FSM states: WAIT -> STEP0 -> STEP1 -> STEP2 -> STEP3 -> LOAD -> WAIT.
  - WAIT: cmd_ready = 1. On frame_tick, go to STEP0 next cycle.
  - STEPn: one cycle per channel n, updating cur[n]:
    - if cur < tgt: cur += min(STEP, tgt-cur)
    - if cur > tgt: cur -= min(STEP, cur-tgt)
    - else: no change.
    - Arithmetic uses 9-bit intermediates; no overshoot, no wrap below 0 or above 255.
  - LOAD: nextangle = 1 for exactly this cycle; angle1..4 already hold the updated cur values. Go to WAIT.
  - Timing: nextangle asserts 5 cycles after frame_tick.
  - angle outputs are registered and change only in STEP states.
- Command handshake:
  - Transfer occurs when cmd_valid && cmd_ready.
  - tgt[cmd_chan] <= min(cmd_angle, MAX_ANGLE).
  - cmd_ready = 0 in STEP0..3 and LOAD. The requester must hold cmd_valid and its payload until accepted.
  - A command accepted on the frame_tick cycle is visible to that frame's STEP pass.
  - Repeated commands to the same channel: the last accepted one wins.
- busy:
  - Registered. busy = OR over n of (cur[n] != tgt[n]).
  - Updates the cycle after any tgt or cur change.
- No command while cur == tgt: nextangle still pulses every frame with unchanged angles, refreshing the PWM.

Optional Feature:
- Macro: SERVO_SLEW_EN.
- Defined: STEP-limited slewing as above.
- Not defined: each STEPn sets cur[n] = tgt[n] directly, so a target is reached in one frame. The STEP parameter is ignored. Handshake, timing and nextangle cadence are unchanged.

Test Plan:
- Reset check (FRAME_CYCLES=16): assert rst 3 cycles.
  -> angle1..4 = 90, nextangle = 0, busy = 0.
  -> first frame_tick at cycle 15 after rst release; nextangle at cycle 20.
- Slew up (STEP=2): write chan0 = 100.
  -> busy = 1; angle1 = 92, 94, ... 100 on successive nextangle pulses (5 frames).
  -> busy = 0 after the 5th frame; other channels stay 90.
- Non-multiple and down slew: write chan2 = 85 (STEP=2).
  -> angle3 = 88, 86, 85; no undershoot to 84.
- Clamp: write chan3 = 250.
  -> tgt = 180; angle4 climbs and settles at 180, never exceeds it.
- Handshake stall: hold cmd_valid with chan1 = 10 asserted across STEP0..LOAD.
  -> cmd_ready = 0 for those 5 cycles; accepted on the first WAIT cycle; exactly one write occurs.
  -> A command on the frame_tick cycle is reflected in the same frame's nextangle.
- Reset mid-step: assert rst during STEP2.
  -> no nextangle that frame; all angles = 90; counter restarts at 0.
  -> With SERVO_SLEW_EN undefined: write chan0 = 0 -> angle1 = 0 at the next nextangle.
